// File: rtl/cfg_chain_pkg.sv
// Shared types and sizing helpers for the configuration-chain sequencer.
// Word count and last-word length are derived here so every user agrees on them.
package cfg_chain_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SHIFT = 3'd2,
      UPD   = 3'd3,
      FIN   = 3'd4
   } state_e;

   function automatic int f_nwords(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // The final word only carries whatever the chain has left over.
   function automatic int f_last_bits(input int chain_len, input int word_w);
      return chain_len - (f_nwords(chain_len, word_w) - 1) * word_w;
   endfunction

endpackage

// File: rtl/cfg_chain_shreg.sv
// Per-word shift register: parallel load, serial out to the chain head,
// LSB-first capture of the chain tail, and the bit counter that ends a word.
module cfg_chain_shreg #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              so_i,
   input  logic [CNT_W-1:0]  nbits_i,
   output logic              si_o,
   output logic [WORD_W-1:0] cap_o,
   output logic              word_done_o
);

   logic [WORD_W-1:0] sh_q, sh_d;
   logic [WORD_W-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc_s;

   assign cnt_inc_s   = cnt_q + CNT_W'(1);
   assign word_done_o = shift_i && (cnt_inc_s == nbits_i);
   assign si_o        = sh_q[0];
   assign cap_o       = cap_q;

   // Load captures bit 0 on the edge that opens the first shift; every later
   // shift edge captures the next tail bit, except after the word's last bit.
   always_comb begin
      sh_d  = sh_q;
      cap_d = cap_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         sh_d  = '0;
         cap_d = '0;
         cnt_d = '0;
      end else if (load_i) begin
         sh_d  = data_i;
         cap_d = WORD_W'(so_i);
         cnt_d = '0;
      end else if (shift_i) begin
         sh_d  = sh_q >> 1;
         cnt_d = cnt_inc_s;
         if (cnt_inc_s < nbits_i) begin
            cap_d = cap_q | (WORD_W'(so_i) << cnt_inc_s);
         end else begin
            cap_d = cap_q;
         end
      end else begin
         sh_d  = sh_q;
         cap_d = cap_q;
         cnt_d = cnt_q;
      end
   end

   // Shift, capture and bit-count state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         cap_q <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cap_q <= cap_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Load/readback sequencer for a negative-edge scan configuration chain.
// Every output is registered from the next state so it lines up with the state.
module cfg_chain_ctrl
   import cfg_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              IN_VALID,
   input  logic [WORD_W-1:0] IN_DATA,
   output logic              IN_READY,
   output logic              SE,
   output logic              SI_OUT,
   input  logic              SO_IN,
   output logic              UPDATE,
   output logic              OUT_VALID,
   output logic [WORD_W-1:0] OUT_DATA,
   output logic              BUSY,
   output logic              DONE
);

   localparam int NWORDS    = f_nwords(CHAIN_LEN, WORD_W);
   localparam int LAST_BITS = f_last_bits(CHAIN_LEN, WORD_W);
   localparam int CNT_W     = $clog2(WORD_W + 1);
   localparam int WCNT_W    = $clog2(NWORDS + 1);

   localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(NWORDS - 1);
   localparam logic [CNT_W-1:0]  FULL_BITS   = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0]  LAST_W_BITS = CNT_W'(LAST_BITS);

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

   logic                in_ready_q, in_ready_d;
   logic                se_q, se_d;
   logic                update_q, update_d;
   logic                out_valid_q, out_valid_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                hs_s;
   logic                shift_s;
   logic                clr_s;
   logic                last_word_s;
   logic                word_done_s;
   logic [CNT_W-1:0]    nbits_s;
   logic [WORD_W-1:0]   cap_s;
   logic                si_s;

   assign hs_s        = in_ready_q && IN_VALID;
   assign shift_s     = (state_q == SHIFT);
   assign clr_s       = (state_d == IDLE);
   assign last_word_s = (wcnt_q == LAST_WORD);
   assign nbits_s     = last_word_s ? LAST_W_BITS : FULL_BITS;

   cfg_chain_shreg #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_shreg (
      .clk_i       (CLK),
      .rst_i       (RST),
      .clr_i       (clr_s),
      .load_i      (hs_s),
      .shift_i     (shift_s),
      .data_i      (IN_DATA),
      .so_i        (SO_IN),
      .nbits_i     (nbits_s),
      .si_o        (si_s),
      .cap_o       (cap_s),
      .word_done_o (word_done_s)
   );

   // State register and word counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (START) state_d = FETCH;
            else       state_d = IDLE;
         end
         FETCH: begin
            if (hs_s) state_d = SHIFT;
            else      state_d = FETCH;
         end
         SHIFT: begin
            if (word_done_s) state_d = last_word_s ? UPD : FETCH;
            else             state_d = SHIFT;
         end
         UPD:     state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Word counter: advances per finished word, cleared whenever IDLE is next
   always_comb begin
      wcnt_d = wcnt_q;
      if (clr_s) begin
         wcnt_d = '0;
      end else if (word_done_s) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
      end else begin
         wcnt_d = wcnt_q;
      end
   end

   // Output decode from the next state, so registered outputs track the state
   always_comb begin
      in_ready_d  = (state_d == FETCH);
      se_d        = (state_d == SHIFT);
      update_d    = (state_d == UPD);
      done_d      = (state_d == FIN);
      busy_d      = (state_d != IDLE);
      out_valid_d = word_done_s;
      if (word_done_s) begin
         out_data_d = cap_s;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         in_ready_q  <= 1'b0;
         se_q        <= 1'b0;
         update_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         se_q        <= se_d;
         update_q    <= update_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign SE        = se_q;
   assign SI_OUT    = si_s;
   assign UPDATE    = update_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Scoreboard bench: a 12-bit and a 5-bit chain model driven by two controllers.
// Expected readback words are queued at stimulus time and popped on OUT_VALID.
module tb_cfg_chain_ctrl;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---- instance A: CHAIN_LEN=12, WORD_W=8 ----
   logic       start_a, iv_a, ir_a, se_a, si_a, so_a, upd_a, ov_a, busy_a, done_a;
   logic [7:0] id_a, od_a;
   logic [11:0] chain_a;
   logic [31:0] si_log_a;
   int se_cnt_a, upd_cnt_a, done_cnt_a, first_se_a, upd_cyc_a, done_cyc_a;
   logic [7:0] q_a[$];
   assign so_a = chain_a[0];

   cfg_chain_ctrl #(.CHAIN_LEN(12), .WORD_W(8)) u_a (
      .CLK(CLK), .RST(RST), .START(start_a), .IN_VALID(iv_a), .IN_DATA(id_a),
      .IN_READY(ir_a), .SE(se_a), .SI_OUT(si_a), .SO_IN(so_a), .UPDATE(upd_a),
      .OUT_VALID(ov_a), .OUT_DATA(od_a), .BUSY(busy_a), .DONE(done_a)
   );

   // ---- instance B: CHAIN_LEN=5, WORD_W=8 ----
   logic       start_b, iv_b, ir_b, se_b, si_b, so_b, upd_b, ov_b, busy_b, done_b;
   logic [7:0] id_b, od_b;
   logic [4:0] chain_b;
   int se_cnt_b, upd_cnt_b, done_cnt_b, upd_cyc_b;
   logic [7:0] q_b[$];
   assign so_b = chain_b[0];

   cfg_chain_ctrl #(.CHAIN_LEN(5), .WORD_W(8)) u_b (
      .CLK(CLK), .RST(RST), .START(start_b), .IN_VALID(iv_b), .IN_DATA(id_b),
      .IN_READY(ir_b), .SE(se_b), .SI_OUT(si_b), .SO_IN(so_b), .UPDATE(upd_b),
      .OUT_VALID(ov_b), .OUT_DATA(od_b), .BUSY(busy_b), .DONE(done_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_idle_a(input string nm);
      chk(nm, 32'({ir_a, se_a, si_a, upd_a, ov_a, od_a, busy_a, done_a}), 32'd0);
   endtask

   task automatic chk_idle_b(input string nm);
      chk(nm, 32'({ir_b, se_b, si_b, upd_b, ov_b, od_b, busy_b, done_b}), 32'd0);
   endtask

   // Chain models shift on the falling edge while SE is high; monitors check readback
   always @(negedge CLK) begin
      chk("a_ready_only_fetch", 32'(ir_a & (~busy_a | se_a | upd_a | done_a)), 32'd0);
      if (se_a) begin
         if (se_cnt_a < 32) si_log_a[se_cnt_a] = si_a;
         se_cnt_a++;
         if (first_se_a < 0) first_se_a = cyc;
         chain_a = {si_a, chain_a[11:1]};
      end
      if (upd_a) begin upd_cnt_a++; upd_cyc_a = cyc; end
      if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
      if (ov_a) begin
         if (q_a.size() == 0) chk("a_out_unexpected", 32'd1, 32'd0);
         else chk("a_out_data", 32'(od_a), 32'(q_a.pop_front()));
      end
   end

   always @(negedge CLK) begin
      chk("b_ready_only_fetch", 32'(ir_b & (~busy_b | se_b | upd_b | done_b)), 32'd0);
      if (se_b) begin
         se_cnt_b++;
         chain_b = {si_b, chain_b[4:1]};
      end
      if (upd_b) begin upd_cnt_b++; upd_cyc_b = cyc; end
      if (done_b) done_cnt_b++;
      if (ov_b) begin
         if (q_b.size() == 0) chk("b_out_unexpected", 32'd1, 32'd0);
         else chk("b_out_data", 32'(od_b), 32'(q_b.pop_front()));
      end
   end

   task automatic wait_hs_a(input string nm);
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (ir_a && iv_a) break;
      end
      if (n >= 200) chk(nm, 32'd0, 32'd1);
   endtask

   task automatic wait_done_a();
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (done_a) break;
      end
      if (n >= 200) chk("a_timeout_done", 32'd0, 32'd1);
      #1;
   endtask

   // Full two-word sequence on A; returns just after the DONE cycle's falling edge
   task automatic seq_a(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                        input bit mid_start, input bit b2b,
                        input logic [7:0] e0, input logic [7:0] e1);
      int t;
      int sn;
      q_a.push_back(e0);
      q_a.push_back(e1);
      if (b2b) begin
         start_a = 1'b1;
         @(posedge CLK); #1;
      end else begin
         @(posedge CLK); #1;
         start_a = 1'b1;
      end
      t = cyc;
      se_cnt_a = 0; upd_cnt_a = 0; done_cnt_a = 0; first_se_a = -1; si_log_a = '0;
      iv_a = 1'b1; id_a = w0;
      @(posedge CLK); #1;
      start_a = 1'b0;
      wait_hs_a("a_timeout_hs0");
      @(posedge CLK); #1;
      if (mid_start) begin
         start_a = 1'b1;
         @(posedge CLK); #1;
         start_a = 1'b0;
      end
      if (stall > 0) begin
         iv_a = 1'b0;
         for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (ir_a) break;
         end
         sn = se_cnt_a;
         repeat (stall) @(posedge CLK);
         #1;
         chk("a_stall_no_se", se_cnt_a, sn);
      end
      id_a = w1; iv_a = 1'b1;
      wait_hs_a("a_timeout_hs1");
      @(posedge CLK); #1;
      iv_a = 1'b0;
      wait_done_a();
      chk("a_se_total", se_cnt_a, 12);
      chk("a_update_once", upd_cnt_a, 1);
      chk("a_done_once", done_cnt_a, 1);
      chk("a_first_se_lat", first_se_a, t + 2);
      chk("a_update_lat", upd_cyc_a, t + 15 + stall);
      chk("a_done_after_upd", done_cyc_a, upd_cyc_a + 1);
      chk("a_si_seq", si_log_a, 32'({w1[3:0], w0}));
      chk("a_sb_drained", q_a.size(), 0);
   endtask

   initial begin
      int n;
      int tb;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int tb;
      RST = 1'b1;
      start_a = 1'b0; iv_a = 1'b0; id_a = 8'h00;
      start_b = 1'b0; iv_b = 1'b0; id_b = 8'h00;
      chain_a = 12'hABC; chain_b = 5'b10110;
      se_cnt_a = 0; upd_cnt_a = 0; done_cnt_a = 0; first_se_a = -1; si_log_a = '0;
      upd_cyc_a = 0; done_cyc_a = 0;
      se_cnt_b = 0; upd_cnt_b = 0; done_cnt_b = 0; upd_cyc_b = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_idle_a("a_reset_vals");
      chk_idle_b("b_reset_vals");
      @(posedge CLK); #1;
      RST = 1'b0;

      // Basic load: 0x5A, 0x03 into 0xABC -> readback 0xBC, 0x0A, chain 0x35A
      seq_a(8'h5A, 8'h03, 0, 1'b0, 1'b0, 8'hBC, 8'h0A);
      chk("a_chain_t1", 32'(chain_a), 32'h35A);

      // Five-cycle input stall before the second word
      seq_a(8'hC3, 8'h09, 5, 1'b0, 1'b0, 8'h5A, 8'h03);
      chk("a_chain_t2", 32'(chain_a), 32'h9C3);

      // Reset on the 6th shift cycle: chain left at 0x9C3 >> 6 = 0x027
      @(posedge CLK); #1;
      start_a = 1'b1; iv_a = 1'b1; id_a = 8'h00;
      se_cnt_a = 0; upd_cnt_a = 0; done_cnt_a = 0;
      @(posedge CLK); #1;
      start_a = 1'b0;
      n = 0;
      for (int k = 0; k < 100 && n < 6; k++) begin
         @(negedge CLK);
         if (se_a) n++;
      end
      chk("a_rst_reach_se6", n, 6);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; iv_a = 1'b0;
      @(negedge CLK);
      chk_idle_a("a_rst_mid_outputs");
      repeat (10) @(posedge CLK);
      #1;
      chk("a_rst_se_count", se_cnt_a, 6);
      chk("a_rst_no_update", upd_cnt_a, 0);
      chk("a_rst_no_done", done_cnt_a, 0);
      chk("a_rst_chain", 32'(chain_a), 32'h027);
      chk("a_rst_no_out", q_a.size(), 0);
      seq_a(8'h5A, 8'h03, 0, 1'b0, 1'b0, 8'h27, 8'h00);
      chk("a_chain_t3", 32'(chain_a), 32'h35A);

      // IN_VALID in IDLE is ignored; START during SHIFT is ignored
      iv_a = 1'b1; id_a = 8'h11;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("a_idle_no_ready", 32'(ir_a), 32'd0);
         chk("a_idle_not_busy", 32'(busy_a), 32'd0);
      end
      chk("a_idle_no_se", se_cnt_a, 12);
      seq_a(8'h11, 8'h02, 0, 1'b1, 1'b0, 8'h5A, 8'h03);
      repeat (20) @(posedge CLK);
      #1;
      chk("a_one_seq_se", se_cnt_a, 12);
      chk("a_one_seq_upd", upd_cnt_a, 1);
      chk("a_chain_t4", 32'(chain_a), 32'h211);

      // Back-to-back: START during FIN ignored, START in the next IDLE cycle taken
      seq_a(8'hE7, 8'h04, 0, 1'b0, 1'b0, 8'h11, 8'h02);
      seq_a(8'h5A, 8'h03, 0, 1'b0, 1'b1, 8'hE7, 8'h04);
      chk("a_chain_t5", 32'(chain_a), 32'h35A);

      // Short chain: 5 bits, word 0xFF, chain 0b10110 -> readback 0x16, chain 0b11111
      q_b.push_back(8'h16);
      @(posedge CLK); #1;
      start_b = 1'b1; iv_b = 1'b1; id_b = 8'hFF; tb = cyc;
      @(posedge CLK); #1;
      start_b = 1'b0;
      for (n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (ir_b && iv_b) break;
      end
      if (n >= 200) chk("b_timeout_hs", 32'd0, 32'd1);
      @(posedge CLK); #1;
      iv_b = 1'b0;
      for (n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (done_b) break;
      end
      if (n >= 200) chk("b_timeout_done", 32'd0, 32'd1);
      #1;
      chk("b_se_total", se_cnt_b, 5);
      chk("b_chain", 32'(chain_b), 32'h1F);
      chk("b_update_once", upd_cnt_b, 1);
      chk("b_update_lat", upd_cyc_b, tb + 7);
      chk("b_done_once", done_cnt_b, 1);
      chk("b_sb_drained", q_b.size(), 0);

      repeat (3) @(posedge CLK);
      #1;
      chk("a_final_drained", q_a.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
